mmio_xbar_stage: RTL and testbench

- Parametrised successor to the memory-stage MMIO path: decodes a load/store into one of NUM_SLAVES equal-sized MMIO windows and runs a multi-cycle request/ack handshake with the selected peripheral.
- Stalls the pipeline while the access is outstanding.
- Adds byte-lane handling, a misalignment check, unmapped-address detection and a per-access timeout.
- Sits in the MEM stage beside data_mem; the stage steers only in-window accesses here.

---
 rtl/rv_pkg.sv | 44 ++++
 rtl/mmio_lane_align.sv | 44 ++++
 rtl/mmio_xbar_stage.sv | 161 ++++++++++++++++
 tb/tb_mmio_xbar_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared types for the MEM-stage MMIO path.
//   mem_size_e   - access size encoding (BYTE/HWORD/WORD)
//   mmio_fault_e - completion fault cause
//   mmio_state_e - MMIO access FSM states
//   mmio_req_t   - latched MMIO request
//   is_misaligned() - natural-alignment check for a size/low-address pair
package rv_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HWORD = 2'd1,
    SZ_WORD  = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_UNMAPPED = 2'd2,
    FLT_TIMEOUT  = 2'd3
  } mmio_fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mmio_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_size_e   size;
    logic        sign_ext;
  } mmio_req_t;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SZ_HWORD: return lo[0];
      SZ_WORD:  return (lo != 2'b00);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mmio_lane_align.sv
// mmio_lane_align: combinational byte-lane steering.
//   Write side: byte enables and lane-replicated store data.
//   Read side : shift the addressed lanes down and zero/sign-extend.
// Ports:
//   size_i, addr_lo_i, sign_ext_i - access descriptor
//   wdata_i -> be_o, wdata_o       - store path
//   rdata_i -> rdata_o             - load path
module mmio_lane_align
  import rv_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [15:0] sh;

  always_comb begin
    sh = 16'(rdata_i >> {addr_lo_i, 3'b000});
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext_i & sh[7]}}, sh[7:0]};
      end
      SZ_HWORD: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_ext_i & sh[15]}}, sh[15:0]};
      end
      default: begin
        be_o    = 4'hF;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mmio_xbar_stage.sv
// mmio_xbar_stage: MEM-stage MMIO crossbar. Decodes an access into one of
// NUM_SLAVES windows of 2^WIN_BITS bytes starting at MMIO_BASE, runs a
// sel/ack handshake with that slave while stalling, and returns one DONE
// cycle with load data or a fault cause.
// Ports:
//   i_clk, i_rst (sync, active high)
//   i_req_*  - request from MEM stage;  o_stall - hold pipeline
//   o_rdata, o_done, o_fault, o_fault_cause - completion (DONE cycle only)
//   o_slv_*  - slave-side request, nonzero only while BUSY
//   i_slv_rdata, i_slv_ack - per-slave response (slave k at [32k+:32])
module mmio_xbar_stage
  import rv_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter int          WIN_BITS       = 8,
  parameter logic [31:0] MMIO_BASE      = 32'h100,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  input  logic                    i_req_we,
  input  logic [31:0]             i_req_addr,
  input  logic [31:0]             i_req_wdata,
  input  logic [1:0]              i_req_size,
  input  logic                    i_req_sign_ext,
  output logic                    o_stall,
  output logic [31:0]             o_rdata,
  output logic                    o_done,
  output logic                    o_fault,
  output logic [1:0]              o_fault_cause,
  output logic [NUM_SLAVES-1:0]   o_slv_sel,
  output logic                    o_slv_we,
  output logic [WIN_BITS-1:0]     o_slv_addr,
  output logic [31:0]             o_slv_wdata,
  output logic [3:0]              o_slv_be,
  input  logic [32*NUM_SLAVES-1:0] i_slv_rdata,
  input  logic [NUM_SLAVES-1:0]   i_slv_ack
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  mmio_state_e       state_q;
  mmio_req_t         req_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q, fault_q;
  mmio_fault_e       cause_q;
  logic [31:0]       rdata_q;

  // Request decode (IDLE only)
  mem_size_e   req_size;
  logic [31:0] off, slot;
  logic        unmapped, misalign;

  assign req_size = mem_size_e'(i_req_size);
  assign off      = i_req_addr - MMIO_BASE;
  assign slot     = off >> WIN_BITS;
  // Addresses below the base wrap to a huge offset, but test explicitly anyway.
  assign unmapped = (i_req_addr < MMIO_BASE) || (slot >= 32'(NUM_SLAVES));
  assign misalign = is_misaligned(req_size, i_req_addr[1:0]);

  // Selected-slave response
  logic        busy, ack_sel, tmo;
  logic [31:0] sel_rdata, rd_ext, wd_rep;
  logic [3:0]  be;

  assign busy      = (state_q == ST_BUSY);
  assign ack_sel   = i_slv_ack[idx_q];
  assign sel_rdata = i_slv_rdata[{idx_q, 5'd0} +: 32];
  assign tmo       = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  mmio_lane_align u_align (
    .size_i     (req_q.size),
    .addr_lo_i  (req_q.addr[1:0]),
    .sign_ext_i (req_q.sign_ext),
    .wdata_i    (req_q.wdata),
    .rdata_i    (sel_rdata),
    .be_o       (be),
    .wdata_o    (wd_rep),
    .rdata_o    (rd_ext)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= FLT_NONE;
      rdata_q <= '0;
    end else begin
      // Completion outputs live for exactly the DONE cycle.
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= FLT_NONE;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            req_q <= '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata,
                       size: req_size, sign_ext: i_req_sign_ext};
            idx_q <= off[WIN_BITS +: IDX_W];
            cnt_q <= '0;
            if (misalign) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              cause_q <= FLT_MISALIGN;
            end else if (unmapped) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              cause_q <= FLT_UNMAPPED;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Ack is tested first so it wins over a same-cycle timeout.
          if (ack_sel) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            rdata_q <= req_q.we ? 32'd0 : rd_ext;
          end else if (tmo) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
            cause_q <= FLT_TIMEOUT;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_stall       = ((state_q == ST_IDLE) && i_req_valid) || busy;
  assign o_done        = done_q;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;
  assign o_rdata       = rdata_q;

  assign o_slv_sel   = busy ? (NUM_SLAVES'(1) << idx_q) : '0;
  assign o_slv_we    = busy & req_q.we;
  assign o_slv_addr  = busy ? req_q.addr[WIN_BITS-1:0] : '0;
  assign o_slv_wdata = busy ? wd_rep : '0;
  assign o_slv_be    = busy ? be : '0;

  // Window offset above WIN_BITS is only needed for decode, not for the slave.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_q.addr[31:WIN_BITS];

endmodule

// File: tb/tb_mmio_xbar_stage.sv
module tb_mmio_xbar_stage;
  import rv_pkg::*;

  localparam int NS = 4;
  localparam int WB = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req_valid, i_req_we, i_req_sign_ext;
  logic [31:0]       i_req_addr, i_req_wdata;
  logic [1:0]        i_req_size;
  logic              o_stall, o_done, o_fault, o_slv_we;
  logic [31:0]       o_rdata, o_slv_wdata;
  logic [1:0]        o_fault_cause;
  logic [NS-1:0]     o_slv_sel, i_slv_ack;
  logic [WB-1:0]     o_slv_addr;
  logic [3:0]        o_slv_be;
  logic [32*NS-1:0]  i_slv_rdata;

  always #5 clk = ~clk;

  mmio_xbar_stage #(.NUM_SLAVES(NS), .WIN_BITS(WB), .MMIO_BASE(32'h100),
                    .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_size(i_req_size), .i_req_sign_ext(i_req_sign_ext),
    .o_stall(o_stall), .o_rdata(o_rdata), .o_done(o_done), .o_fault(o_fault),
    .o_fault_cause(o_fault_cause), .o_slv_sel(o_slv_sel), .o_slv_we(o_slv_we),
    .o_slv_addr(o_slv_addr), .o_slv_wdata(o_slv_wdata), .o_slv_be(o_slv_be),
    .i_slv_rdata(i_slv_rdata), .i_slv_ack(i_slv_ack)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    int          lat;   // cycles from accept through DONE
    logic [3:0]  sel;   // OR of o_slv_sel seen during the access
    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  sa;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic fault, input logic [1:0] cause,
                              input int lat, input logic [3:0] sel, input logic [3:0] be,
                              input logic [31:0] wd, input logic [7:0] sa, input logic we);
    exp_t e;
    e.rdata = rdata; e.fault = fault; e.cause = cause; e.lat = lat; e.sel = sel;
    e.be = be; e.wd = wd; e.sa = sa; e.we = we;
    return e;
  endfunction

  // Slave model: ack the selected slave on BUSY cycle ack_at (1-based), plus
  // spurious acks on the slaves in spur. Unselected slaves present junk data.
  int          ack_at = 0;
  int          bcnt   = 0;
  logic [3:0]  spur   = '0;
  logic [31:0] rd_val = '0;

  always @(negedge clk) begin
    if (o_slv_sel == '0) bcnt = 0;
    else                 bcnt = bcnt + 1;
    for (int k = 0; k < NS; k++)
      i_slv_rdata[32*k +: 32] = o_slv_sel[k] ? rd_val : (32'h5A5A0000 | 32'(k));
    i_slv_ack = spur | ((o_slv_sel != '0 && bcnt == ack_at) ? o_slv_sel : 4'b0000);
  end

  // Monitor: measures stall run and slave-side request, checks on each o_done.
  int          run = 0;
  logic [3:0]  sel_s, be_s;
  logic [31:0] wd_s;
  logic [7:0]  sa_s;
  logic        we_s;
  exp_t        me;

  always @(negedge clk) begin
    if (rst) begin
      run = 0; sel_s = '0; be_s = '0; wd_s = '0; sa_s = '0; we_s = 1'b0;
    end else if (o_done) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got o_done=1, expected no completion");
      end else begin
        me = sb.pop_front();
        chk("rdata", o_rdata, me.rdata);
        chk("fault", 32'(o_fault), 32'(me.fault));
        chk("cause", 32'(o_fault_cause), 32'(me.cause));
        chk("latency", 32'(run + 1), 32'(me.lat));
        chk("slv_sel", 32'(sel_s), 32'(me.sel));
        chk("slv_be", 32'(be_s), 32'(me.be));
        chk("slv_wdata", wd_s, me.wd);
        chk("slv_addr", 32'(sa_s), 32'(me.sa));
        chk("slv_we", 32'(we_s), 32'(me.we));
        chk("done_stall", 32'(o_stall), 32'd0);
      end
      run = 0; sel_s = '0; be_s = '0; wd_s = '0; sa_s = '0; we_s = 1'b0;
    end else begin
      if (o_stall) run++;
      if (o_slv_sel != '0) begin
        sel_s = sel_s | o_slv_sel;
        be_s = o_slv_be; wd_s = o_slv_wdata; sa_s = o_slv_addr; we_s = o_slv_we;
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sx, input int ackat,
                        input logic [3:0] sp, input logic [31:0] rdv, input exp_t e);
    int n;
    sb.push_back(e);
    @(posedge clk); #1;
    ack_at = ackat; spur = sp; rd_val = rdv;
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wd;
    i_req_size = sz; i_req_sign_ext = sx;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!o_done && n < 40);
    if (!o_done) begin
      n_tests++; n_fail++;
      $display("FAIL done_wait: got no o_done in 40 cycles for addr %h, expected completion", addr);
    end
    i_req_valid = 1'b0; spur = '0; ack_at = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_req_size = 2'd0; i_req_sign_ext = 1'b0; i_slv_ack = '0; i_slv_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_cause", 32'(o_fault_cause), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_sel", 32'(o_slv_sel), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // LW slave1, ack on 2nd BUSY cycle
    access(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 2, 4'b0, 32'hDEADBEEF,
           mk(32'hDEADBEEF, 1'b0, 2'd0, 4, 4'b0010, 4'hF, 32'h0, 8'h00, 1'b0));
    // LB signed / unsigned at byte lane 3
    access(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 1, 4'b0, 32'h80123456,
           mk(32'hFFFFFF80, 1'b0, 2'd0, 3, 4'b0001, 4'b1000, 32'h0, 8'h03, 1'b0));
    access(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 1, 4'b0, 32'h80123456,
           mk(32'h00000080, 1'b0, 2'd0, 3, 4'b0001, 4'b1000, 32'h0, 8'h03, 1'b0));
    // SH to slave2, upper half
    access(1'b1, 32'h302, 32'h0000ABCD, 2'd1, 1'b0, 1, 4'b0, 32'h11111111,
           mk(32'h0, 1'b0, 2'd0, 3, 4'b0100, 4'b1100, 32'hABCDABCD, 8'h02, 1'b1));
    // SB replication
    access(1'b1, 32'h1FD, 32'h000000A5, 2'd0, 1'b0, 1, 4'b0, 32'h22222222,
           mk(32'h0, 1'b0, 2'd0, 3, 4'b0001, 4'b0010, 32'hA5A5A5A5, 8'hFD, 1'b1));
    // LH signed at upper half
    access(1'b0, 32'h106, 32'h0, 2'd1, 1'b1, 1, 4'b0, 32'h80011234,
           mk(32'hFFFF8001, 1'b0, 2'd0, 3, 4'b0001, 4'b1100, 32'h0, 8'h06, 1'b0));
    // Faults: misalign word/half, unmapped above and below
    access(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 1, 4'b0, 32'h33333333,
           mk(32'h0, 1'b1, 2'd1, 2, 4'b0, 4'b0, 32'h0, 8'h00, 1'b0));
    access(1'b0, 32'h101, 32'h0, 2'd1, 1'b0, 1, 4'b0, 32'h33333333,
           mk(32'h0, 1'b1, 2'd1, 2, 4'b0, 4'b0, 32'h0, 8'h00, 1'b0));
    access(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, 1, 4'b0, 32'h33333333,
           mk(32'h0, 1'b1, 2'd2, 2, 4'b0, 4'b0, 32'h0, 8'h00, 1'b0));
    access(1'b1, 32'h0FC, 32'h1, 2'd2, 1'b0, 1, 4'b0, 32'h33333333,
           mk(32'h0, 1'b1, 2'd2, 2, 4'b0, 4'b0, 32'h0, 8'h00, 1'b0));
    // Timeout after 16 BUSY cycles
    access(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 0, 4'b0, 32'h44444444,
           mk(32'h0, 1'b1, 2'd3, 18, 4'b1000, 4'hF, 32'h0, 8'h00, 1'b0));
    // Ack on the terminal count cycle wins
    access(1'b0, 32'h404, 32'h0, 2'd2, 1'b0, 16, 4'b0, 32'hCAFEF00D,
           mk(32'hCAFEF00D, 1'b0, 2'd0, 18, 4'b1000, 4'hF, 32'h0, 8'h04, 1'b0));
    // Spurious acks from unselected slaves are ignored
    access(1'b0, 32'h208, 32'h0, 2'd2, 1'b0, 3, 4'b1101, 32'h12345678,
           mk(32'h12345678, 1'b0, 2'd0, 5, 4'b0010, 4'hF, 32'h0, 8'h08, 1'b0));

    // Reset in the third BUSY cycle drops the access
    @(posedge clk); #1;
    ack_at = 0; i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h300; i_req_size = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("busy3_sel", 32'(o_slv_sel), 32'(4'b0100));
    rst = 1'b1; i_req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_stall", 32'(o_stall), 32'd0);
    chk("rstmid_done", 32'(o_done), 32'd0);
    chk("rstmid_sel", 32'(o_slv_sel), 32'd0);
    chk("rstmid_be", 32'(o_slv_be), 32'd0);
    chk("rstmid_rdata", o_rdata, 32'd0);
    repeat (3) @(negedge clk);

    access(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 1, 4'b0, 32'h0BADF00D,
           mk(32'h0BADF00D, 1'b0, 2'd0, 3, 4'b0100, 4'hF, 32'h0, 8'h00, 1'b0));

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
